morse_key_decoder: RTL and testbench
====================================

Name: morse_key_decoder

Overview:
- Upstream stage of the answer checker: turns the raw Morse push-button into a letter code.
- Debounces the key, then classifies each press as a dot or a dash by its duration, measured in `tick` units.
- Ends a letter after a long enough release gap, looks the symbol pattern up in the Morse table, and presents `letter[5:0]` with a one-cycle `newLetter` strobe to the checker.
- Letter code space matches the question generator: 0–25 = A–Z, 26–35 = digits 0–9, 63 = invalid.

Parameters:
- DOT_MAX_TICKS, 20: a press of at most this many ticks is a dot; anything longer is a dash.
- LETTER_GAP_TICKS, 50: this many consecutive released ticks ends the current letter.
- DEBOUNCE_TICKS, 2: consecutive tick samples at the new level required to accept a key change.

Ports:
- clock  in  1  system clock (100 MHz).
- clear  in  1  asynchronous active-low reset; all state clears immediately when low.
- tick  in  1  one-cycle timebase enable pulse from the 10 ms divider.
- key  in  1  raw push-button, asynchronous to clock, active-high.
- letter  out  6  last decoded letter code, held until the next emit.
- newLetter  out  1  one-cycle strobe, asserted in the same cycle `letter` updates.
- keyLevel  out  1  debounced key level, for an LED.
- symLen  out  3  number of symbols captured so far in the current letter (0–5).
- symBits  out  5  captured symbols, 1 = dash; the first symbol sits in bit symLen-1 (shift-left insertion).
- overflow  out  1  high once a 6th symbol is entered; cleared on emit.

Behaviour:
- Reset (clear = 0, asynchronous) drives these values:
  - letter = 6'd63, newLetter = 0, keyLevel = 0, symLen = 0, symBits = 0, overflow = 0.
  - FSM = IDLE; all counters = 0.
- Synchronizer: `key` passes through a 2-flop synchronizer on every clock.
- Debounce:
  - Evaluated only on cycles where tick = 1.
  - keyLevel toggles after DEBOUNCE_TICKS consecutive ticks sample a synchronized value different from keyLevel.
  - Any tick that samples a value equal to keyLevel resets the debounce count.
- Counters:
  - All duration counters advance only on tick cycles.
  - Width is 8 bits, saturating at 255; they never wrap.
- FSM states: IDLE, PRESS, GAP, EMIT.
  - IDLE: keyLevel rising → PRESS, with pressCnt = 0.
  - PRESS:
    - pressCnt increments on each tick.
    - keyLevel falling → classify: dash if pressCnt > DOT_MAX_TICKS, else dot.
    - If symLen < 5: shift the symbol into symBits and increment symLen.
    - If symLen = 5: set overflow and leave symBits/symLen unchanged.
    - Then go to GAP with gapCnt = 0.
  - GAP:
    - gapCnt increments on each tick.
    - keyLevel rising before the timeout → PRESS, with pressCnt = 0 and gapCnt discarded.
    - gapCnt reaching LETTER_GAP_TICKS → EMIT.
  - EMIT (exactly one cycle):
    - letter = table lookup of (symLen, symBits).
    - newLetter = 1.
    - Clear symLen, symBits and overflow; return to IDLE.
- Table: standard ITU Morse for A–Z and 0–9. Any of the following yields letter = 63:
  - a pattern not in the table;
  - overflow = 1;
  - symLen = 0 (which cannot actually occur).
- Latency: newLetter rises on the clock edge following the tick on which gapCnt reaches LETTER_GAP_TICKS.
- newLetter is never asserted in two consecutive cycles.
- tick and a synchronized key change in the same cycle: the debounce sample uses the current synchronized value.
- PRESS reaching saturation at 255 stays a dash; no timeout occurs in PRESS.
- clear asserted mid-press or mid-gap: the partial letter is discarded and no newLetter is issued.
- Emit occurs solely on gap timeout; there is no emit on reset release.

Test Plan:
- Debounce:
  - Stimulus: key high for 1 tick only.
  - Required: keyLevel stays 0, symLen stays 0, no newLetter.
- Single dot:
  - Stimulus: key high 10 ticks, then low 60 ticks.
  - Required: exactly one newLetter pulse with letter = 4 ('E'), arriving 1 cycle after the 50th gap tick; symLen returns to 0.
- Dot then dash:
  - Stimulus: press 10 ticks, release 10, press 30 ticks, release 60.
  - Required: symBits = 5'b00001 and symLen = 2 before emit; letter = 0 ('A').
- Five dashes:
  - Stimulus: each press 30 ticks with 10-tick gaps, then 60 ticks released.
  - Required: letter = 26 (digit 0).
  - Boundary: a press of exactly 20 ticks is a dot; a press of 21 ticks is a dash.
- Overflow:
  - Stimulus: six dots, then a gap timeout.
  - Required: overflow = 1 after the 6th dot, symLen stays 5; on timeout letter = 63 with newLetter pulse, after which overflow = 0.
- Reset mid-letter:
  - Stimulus: after two dots, pulse clear low for 3 cycles.
  - Required: all outputs at reset values immediately, letter = 63, no newLetter ever issued for the partial letter.

Source files
------------

// File: rtl/morse_key_decoder.sv
// Morse key front end: synchronizes and debounces the push-button, classifies
// presses as dot/dash, and emits a decoded letter code after a release gap.
module morse_key_decoder #(
  parameter int unsigned DOT_MAX_TICKS    = 20,
  parameter int unsigned LETTER_GAP_TICKS = 50,
  parameter int unsigned DEBOUNCE_TICKS   = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       key,
  output logic [5:0] letter,
  output logic       newLetter,
  output logic       keyLevel,
  output logic [2:0] symLen,
  output logic [4:0] symBits,
  output logic       overflow
);

  localparam logic [7:0] DOT_LIM = 8'(DOT_MAX_TICKS);
  localparam logic [7:0] GAP_LIM = 8'(LETTER_GAP_TICKS);
  localparam logic [7:0] DB_LIM  = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

  state_t     r_state, w_next;
  logic       r_sync1, r_sync2;
  logic       r_keyLevel;
  logic [7:0] r_dbCnt, r_pressCnt, r_gapCnt;
  logic [2:0] r_symLen;
  logic [4:0] r_symBits;
  logic       r_overflow;
  logic [5:0] r_letter;
  logic [7:0] w_dbNext, w_pressNext, w_gapNext;
  logic       w_toggle, w_rise, w_fall, w_dash;
  logic [5:0] w_lookup;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_dbNext    = sat_inc(r_dbCnt);
  assign w_pressNext = sat_inc(r_pressCnt);
  assign w_gapNext   = sat_inc(r_gapCnt);
  assign w_toggle    = tick && (r_sync2 != r_keyLevel) && (w_dbNext >= DB_LIM);
  assign w_rise      = w_toggle && r_sync2;
  assign w_fall      = w_toggle && !r_sync2;
  // The releasing tick itself counts toward the press duration.
  assign w_dash      = (w_pressNext > DOT_LIM);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_keyLevel <= 1'b0;
      r_dbCnt    <= '0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
      if (tick) begin
        if (r_sync2 == r_keyLevel) begin
          r_dbCnt <= '0;
        end else if (w_dbNext >= DB_LIM) begin
          r_keyLevel <= r_sync2;
          r_dbCnt    <= '0;
        end else begin
          r_dbCnt <= w_dbNext;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_rise) w_next = PRESS;
      PRESS: if (w_fall) w_next = GAP;
      GAP: begin
        if (w_rise)                              w_next = PRESS;
        else if (tick && (w_gapNext >= GAP_LIM)) w_next = EMIT;
      end
      EMIT:    w_next = w_rise ? PRESS : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pressCnt <= '0;
      r_gapCnt   <= '0;
      r_symLen   <= '0;
      r_symBits  <= '0;
      r_overflow <= 1'b0;
      r_letter   <= 6'd63;
    end else begin
      if ((w_next == PRESS) && (r_state != PRESS)) r_pressCnt <= '0;
      else if ((r_state == PRESS) && tick)         r_pressCnt <= w_pressNext;
      if ((w_next == GAP) && (r_state != GAP))     r_gapCnt <= '0;
      else if ((r_state == GAP) && tick)           r_gapCnt <= w_gapNext;
      if ((r_state == PRESS) && w_fall) begin
        if (r_symLen < 3'd5) begin
          r_symBits <= {r_symBits[3:0], w_dash};
          r_symLen  <= r_symLen + 3'd1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
      if (r_state == EMIT) begin
        r_letter   <= w_lookup;
        r_symLen   <= '0;
        r_symBits  <= '0;
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    w_lookup = 6'd63;
    if (!r_overflow) begin
      case ({r_symLen, r_symBits})
        {3'd2, 5'b00001}: w_lookup = 6'd0;
        {3'd4, 5'b01000}: w_lookup = 6'd1;
        {3'd4, 5'b01010}: w_lookup = 6'd2;
        {3'd3, 5'b00100}: w_lookup = 6'd3;
        {3'd1, 5'b00000}: w_lookup = 6'd4;
        {3'd4, 5'b00010}: w_lookup = 6'd5;
        {3'd3, 5'b00110}: w_lookup = 6'd6;
        {3'd4, 5'b00000}: w_lookup = 6'd7;
        {3'd2, 5'b00000}: w_lookup = 6'd8;
        {3'd4, 5'b00111}: w_lookup = 6'd9;
        {3'd3, 5'b00101}: w_lookup = 6'd10;
        {3'd4, 5'b00100}: w_lookup = 6'd11;
        {3'd2, 5'b00011}: w_lookup = 6'd12;
        {3'd2, 5'b00010}: w_lookup = 6'd13;
        {3'd3, 5'b00111}: w_lookup = 6'd14;
        {3'd4, 5'b00110}: w_lookup = 6'd15;
        {3'd4, 5'b01101}: w_lookup = 6'd16;
        {3'd3, 5'b00010}: w_lookup = 6'd17;
        {3'd3, 5'b00000}: w_lookup = 6'd18;
        {3'd1, 5'b00001}: w_lookup = 6'd19;
        {3'd3, 5'b00001}: w_lookup = 6'd20;
        {3'd4, 5'b00001}: w_lookup = 6'd21;
        {3'd3, 5'b00011}: w_lookup = 6'd22;
        {3'd4, 5'b01001}: w_lookup = 6'd23;
        {3'd4, 5'b01011}: w_lookup = 6'd24;
        {3'd4, 5'b01100}: w_lookup = 6'd25;
        {3'd5, 5'b11111}: w_lookup = 6'd26;
        {3'd5, 5'b01111}: w_lookup = 6'd27;
        {3'd5, 5'b00111}: w_lookup = 6'd28;
        {3'd5, 5'b00011}: w_lookup = 6'd29;
        {3'd5, 5'b00001}: w_lookup = 6'd30;
        {3'd5, 5'b00000}: w_lookup = 6'd31;
        {3'd5, 5'b10000}: w_lookup = 6'd32;
        {3'd5, 5'b11000}: w_lookup = 6'd33;
        {3'd5, 5'b11100}: w_lookup = 6'd34;
        {3'd5, 5'b11110}: w_lookup = 6'd35;
        default:          w_lookup = 6'd63;
      endcase
    end
  end

  // Letter is presented combinationally during EMIT so it moves with the strobe.
  always_comb begin
    newLetter = (r_state == EMIT);
    letter    = (r_state == EMIT) ? w_lookup : r_letter;
    keyLevel  = r_keyLevel;
    symLen    = r_symLen;
    symBits   = r_symBits;
    overflow  = r_overflow;
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: tick-level behavioural model built on Morse
// strings, table-driven letter vectors, directed corner cases and random letters.
module tb_morse_key_decoder;

  logic       clock = 1'b0;
  logic       clear, tick, key;
  logic [5:0] letter;
  logic       newLetter, keyLevel, overflow;
  logic [2:0] symLen;
  logic [4:0] symBits;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  morse_key_decoder #(
    .DOT_MAX_TICKS   (20),
    .LETTER_GAP_TICKS(50),
    .DEBOUNCE_TICKS  (2)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .tick     (tick),
    .key      (key),
    .letter   (letter),
    .newLetter(newLetter),
    .keyLevel (keyLevel),
    .symLen   (symLen),
    .symBits  (symBits),
    .overflow (overflow)
  );

  string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
    "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
    "-", "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
    "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  // Reference model state: debounced level, event times in ticks, symbol string.
  logic       m_lvl;
  int         m_run, m_tick, m_rise_t, m_fall_t;
  bit         m_in_gap;
  string      m_syms;
  logic       e_new;
  logic [5:0] e_letter;
  int         pulses;
  logic [5:0] last_letter;

  function automatic logic [5:0] decode(input string s);
    if (s.len() == 0 || s.len() > 5) return 6'd63;
    for (int i = 0; i < 36; i++)
      if (morse_tab[i] == s) return 6'(i);
    return 6'd63;
  endfunction

  function automatic logic [4:0] bits_of(input string s);
    logic [4:0] b = '0;
    for (int i = 0; i < s.len() && i < 5; i++) b = {b[3:0], (s[i] == 8'h2D)};
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 1'b0; m_run = 0; m_in_gap = 0; m_syms = "";
    e_new = 1'b0; e_letter = 6'd63;
  endtask

  task automatic model_tick();
    m_tick++;
    if (key != m_lvl) begin
      m_run++;
      if (m_run >= 2) begin
        m_lvl = key;
        m_run = 0;
        if (key) begin
          m_rise_t = m_tick;
          m_in_gap = 0;
        end else begin
          if (m_tick - m_rise_t > 20) m_syms = {m_syms, "-"};
          else                        m_syms = {m_syms, "."};
          m_fall_t = m_tick;
          m_in_gap = 1;
        end
        return;
      end
    end else begin
      m_run = 0;
    end
    if (m_in_gap && (m_tick - m_fall_t == 50)) begin
      e_new    = 1'b1;
      e_letter = decode(m_syms);
      m_in_gap = 0;
    end
  endtask

  task automatic check();
    int n = m_syms.len();
    chk("newLetter", newLetter, e_new);
    chk("letter", letter, e_letter);
    chk("keyLevel", keyLevel, m_lvl);
    chk("symLen", symLen, (n > 5) ? 5 : n);
    chk("symBits", symBits, bits_of(m_syms));
    chk("overflow", overflow, n > 5);
    if (newLetter === 1'b1) begin
      pulses++;
      last_letter = letter;
    end
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clock);
    if (t) model_tick();
    else if (e_new) begin
      e_new  = 1'b0;
      m_syms = "";
    end
    @(negedge clock);
    check();
  endtask

  task automatic step(input logic k);
    key = k;
    repeat (3) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic hold(input logic k, input int n);
    repeat (n) step(k);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    tick  = 1'b0;
    #1;
    model_reset();
    check();
    repeat (3) begin
      @(negedge clock);
      check();
    end
    clear = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][8:0] dur;
    logic [5:0]      exp;
  } vec_t;
  vec_t tv[$];

  task automatic add_vec(input int n, input int d0, input int d1, input int d2,
                         input int d3, input int d4, input int d5, input int exp);
    vec_t v;
    v.n = 3'(n);
    v.dur[0] = 9'(d0); v.dur[1] = 9'(d1); v.dur[2] = 9'(d2);
    v.dur[3] = 9'(d3); v.dur[4] = 9'(d4); v.dur[5] = 9'(d5);
    v.exp = 6'(exp);
    tv.push_back(v);
  endtask

  initial begin
    int p0, idx;
    string s;
    vec_t v;

    add_vec(1, 10, 0, 0, 0, 0, 0, 4);        // E
    add_vec(2, 10, 30, 0, 0, 0, 0, 0);       // A
    add_vec(1, 30, 0, 0, 0, 0, 0, 19);       // T
    add_vec(5, 30, 30, 30, 30, 30, 0, 26);   // digit 0
    add_vec(1, 20, 0, 0, 0, 0, 0, 4);        // 20 ticks: dot
    add_vec(1, 21, 0, 0, 0, 0, 0, 19);       // 21 ticks: dash
    add_vec(3, 10, 10, 10, 0, 0, 0, 18);     // S
    add_vec(4, 10, 10, 30, 30, 0, 0, 63);    // ..-- not a letter
    add_vec(4, 30, 30, 10, 30, 0, 0, 16);    // Q
    add_vec(5, 10, 10, 10, 10, 10, 0, 31);   // digit 5
    add_vec(1, 260, 0, 0, 0, 0, 0, 19);      // saturating press still a dash
    add_vec(6, 10, 10, 10, 10, 10, 10, 63);  // overflow

    m_tick = 0; m_rise_t = 0; m_fall_t = 0; pulses = 0; last_letter = 6'd63;
    clear = 1'b1; tick = 1'b0; key = 1'b0;
    #1;
    clear = 1'b0;
    #1;
    model_reset();
    check();
    repeat (2) begin
      @(negedge clock);
      check();
    end
    clear = 1'b1;

    // One-tick glitch is rejected by the debouncer.
    p0 = pulses;
    step(1'b1);
    hold(1'b0, 60);
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_symLen", symLen, 0);
    chk("glitch_level", keyLevel, 0);

    // Single dot: strobe lands exactly on the cycle after the 50th gap tick.
    p0 = pulses;
    hold(1'b1, 10);
    hold(1'b0, 51);
    chk("E_early", pulses - p0, 0);
    step(1'b0);
    chk("E_strobe", newLetter, 1);
    chk("E_letter", letter, 4);
    cyc(1'b0);
    chk("E_strobe_off", newLetter, 0);
    chk("E_symLen", symLen, 0);
    hold(1'b0, 8);
    chk("E_count", pulses - p0, 1);

    // Dot then dash: captured pattern visible before emit.
    p0 = pulses;
    hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 30); hold(1'b0, 10);
    chk("A_symBits", symBits, 5'b00001);
    chk("A_symLen", symLen, 2);
    hold(1'b0, 50);
    chk("A_count", pulses - p0, 1);
    chk("A_letter", last_letter, 0);

    // Six dots: overflow set, length pinned at 5, cleared by emit.
    p0 = pulses;
    repeat (6) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_symLen", symLen, 5);
    hold(1'b0, 50);
    chk("ovf_count", pulses - p0, 1);
    chk("ovf_letter", last_letter, 63);
    chk("ovf_cleared", overflow, 0);

    // Reset mid-letter discards the partial letter.
    p0 = pulses;
    hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 10); hold(1'b0, 5);
    do_reset();
    chk("rst_letter", letter, 63);
    chk("rst_symLen", symLen, 0);
    hold(1'b0, 70);
    chk("rst_count", pulses - p0, 0);
    chk("rst_letter_held", letter, 63);

    for (int i = 0; i < tv.size(); i++) begin
      v  = tv[i];
      p0 = pulses;
      for (int j = 0; j < int'(v.n); j++) begin
        hold(1'b1, int'(v.dur[j]));
        hold(1'b0, 10);
      end
      hold(1'b0, 50);
      chk($sformatf("vec%0d_count", i), pulses - p0, 1);
      chk($sformatf("vec%0d_letter", i), last_letter, v.exp);
    end

    for (int r = 0; r < 12; r++) begin
      idx = $urandom_range(0, 35);
      s   = morse_tab[idx];
      p0  = pulses;
      for (int j = 0; j < s.len(); j++) begin
        if (s[j] == 8'h2D) hold(1'b1, $urandom_range(22, 40));
        else               hold(1'b1, $urandom_range(3, 19));
        if (j < s.len() - 1) hold(1'b0, $urandom_range(3, 40));
      end
      if ($urandom_range(0, 1) == 1) begin
        hold(1'b0, 20);
        step(1'b1);
        hold(1'b0, 45);
      end else begin
        hold(1'b0, $urandom_range(55, 70));
      end
      chk($sformatf("rand%0d_count", r), pulses - p0, 1);
      chk($sformatf("rand%0d_letter", r), last_letter, idx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
